// File: rtl/memory_reader_pipelined_if.sv
// Request, response and memory-port bundle for memory_reader_pipelined.
// slave is the reader side, master is the requester/memory side.
interface memory_reader_pipelined_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              s_valid_i;
  logic              s_ready_o;
  logic [ADDR_W-1:0] s_addr_i;
  logic              s_last_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic              mem_enable_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  s_valid_i, s_addr_i, s_last_i,
    input  m_ready_i, mem_data_i,
    output s_ready_o, m_valid_o, m_addr_o,
    output m_data_o, m_last_o,
    output mem_enable_o, mem_addr_o
  );

  modport master (
    output s_valid_i, s_addr_i, s_last_i,
    output m_ready_i, mem_data_i,
    input  s_ready_o, m_valid_o, m_addr_o,
    input  m_data_o, m_last_o,
    input  mem_enable_o, mem_addr_o
  );
endinterface

// File: rtl/memory_reader_pipelined.sv
// Pipelined memory reader: fixed-latency reads land in an output FIFO.
// Occupancy counts in-flight reads too, so the FIFO can never overflow.
module memory_reader_pipelined #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  memory_reader_pipelined_if.slave  bus,
  output logic                      done_o,
  output logic [LW-1:0]             level_o
);

  logic              s_xfer;
  logic              m_xfer;
  logic [LW-1:0]     occ;
  logic [LW-1:0]     cnt;
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic              we;

  logic [MEM_LATENCY-1:0] pv;
  logic [MEM_LATENCY-1:0] pl;
  logic [ADDR_W-1:0]      pa [MEM_LATENCY];

  logic [ADDR_W-1:0]     fa [FIFO_DEPTH];
  logic [DATA_W-1:0]     fd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fl;

  assign m_xfer = bus.m_valid_o & bus.m_ready_i;
  assign s_xfer = bus.s_valid_i & bus.s_ready_o;
  assign we     = pv[MEM_LATENCY-1];

  assign bus.s_ready_o =
    rst_ni & ((occ < LW'(FIFO_DEPTH)) | m_xfer);
  assign bus.mem_enable_o = s_xfer;
  assign bus.mem_addr_o   = bus.s_addr_i;

  assign bus.m_valid_o = (cnt != '0);
  assign bus.m_addr_o  = bus.m_valid_o ? fa[rp] : '0;
  assign bus.m_data_o  = bus.m_valid_o ? fd[rp] : '0;
  assign bus.m_last_o  = bus.m_valid_o & fl[rp];
  assign done_o        = m_xfer & bus.m_last_o;
  assign level_o       = occ;

  // Tag shift register tracking reads until memory data is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv <= '0;
      pl <= '0;
      for (int i = 0; i < MEM_LATENCY; i++)
        pa[i] <= '0;
    end else begin
      pv[0] <= s_xfer;
      pl[0] <= bus.s_last_i;
      pa[0] <= bus.s_addr_i;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  // FIFO storage; contents are only visible while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (we) begin
      fa[wp] <= pa[MEM_LATENCY-1];
      fl[wp] <= pl[MEM_LATENCY-1];
      fd[wp] <= bus.mem_data_i;
    end
  end

  // Pointers, FIFO count and total occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      occ <= '0;
    end else begin
      if (we)
        wp <= wp + PW'(1);
      if (m_xfer)
        rp <= rp + PW'(1);
      unique case ({we, m_xfer})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
      unique case ({s_xfer, m_xfer})
        2'b10:   occ <= occ + LW'(1);
        2'b01:   occ <= occ - LW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/memory_reader_pipelined.md
MEMORY_READER_PIPELINED -- requirements
Module: memory_reader_pipelined

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, cycles from mem_enable_o to valid mem_data_i; legal range 1..4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries; power of two, >= MEM_LATENCY+2.
REQ-005 SHALL have port clk_i  input  1  clock; all state on rising edge. One clock only.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_valid_i  input  1  address request valid.
REQ-008 SHALL have port s_ready_o  output  1  request accepted when high with s_valid_i.
REQ-009 SHALL have port s_addr_i  input  ADDR_W  read address.
REQ-010 SHALL have port s_last_i  input  1  marks final address of a burst.
REQ-011 SHALL have port m_valid_o  output  1  read data valid.
REQ-012 SHALL have port m_ready_i  input  1  downstream accepts data.
REQ-013 SHALL have port m_addr_o  output  ADDR_W  address the current m_data_o was read from.
REQ-014 SHALL have port m_data_o  output  DATA_W  read data.
REQ-015 SHALL have port m_last_o  output  1  final beat of burst, aligned with m_data_o.
REQ-016 SHALL have port mem_enable_o  output  1  memory read strobe.
REQ-017 SHALL have port mem_addr_o  output  ADDR_W  memory address.
REQ-018 SHALL have port mem_data_i  input  DATA_W  memory read data.
REQ-019 SHALL have port done_o  output  1  one-cycle pulse on transfer of a beat with m_last_o high.
REQ-020 SHALL have port level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-021 SHALL define s_transfer = s_valid_i & s_ready_o and m_transfer = m_valid_o & m_ready_i.
REQ-022 SHALL drive mem_enable_o = s_transfer and mem_addr_o = s_addr_i combinationally; no read without accept.
REQ-023 SHALL carry {valid, addr, last} through a MEM_LATENCY-stage shift register, advancing every cycle, independent of m_ready_i.
REQ-024 SHALL, in the cycle the final stage is valid, write {addr, last, mem_data_i} into the FIFO at the end of that cycle.
REQ-025 SHALL drive m_valid_o/m_addr_o/m_data_o/m_last_o from FIFO head; m_valid_o = FIFO non-empty.
REQ-026 SHALL keep occupancy counter = in-flight reads + FIFO entries: +1 on s_transfer, -1 on m_transfer, unchanged when both occur.
REQ-027 SHALL drive s_ready_o = (occupancy < FIFO_DEPTH) | m_transfer; FIFO can never overflow, writes never dropped.
REQ-028 SHALL drive level_o = occupancy.
REQ-029 SHALL give latency: address accepted in cycle t, FIFO empty -> m_valid_o high in cycle t+MEM_LATENCY+1.
REQ-030 SHALL sustain one beat per cycle when s_valid_i and m_ready_i are held high.
REQ-031 SHALL hold m_* outputs stable while m_valid_o & !m_ready_i.
REQ-032 SHALL support simultaneous FIFO write and read, including when FIFO is full at cycle start and when empty (no bypass; written data appears next cycle).
REQ-033 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-034 SHALL preserve request order on the master side.
REQ-035 SHALL pass s_last_i through unaltered; back-to-back bursts need no idle cycle.
REQ-036 SHALL pulse done_o in the cycle of m_transfer & m_last_o.

Reset
REQ-037 SHALL, while rst_ni low, force s_ready_o=0, m_valid_o=0, m_last_o=0, done_o=0, mem_enable_o=0, level_o=0, m_addr_o=0, m_data_o=0.
REQ-038 SHALL discard all in-flight reads and FIFO contents on reset asserted mid-operation; no stale beat after release.
REQ-039 SHALL assert s_ready_o from the first cycle after rst_ni rises.

Verification
REQ-040 Single read, L=1: addr 0x10, mem returns 0xAABB -> m_valid_o at t+2, m_addr_o=0x10, m_data_o=0xAABB.
REQ-041 Streaming, L=2, depth 4, m_ready_i=1: addrs 0..15 -> 16 beats in order on consecutive cycles, level_o never exceeds 4.
REQ-042 Backpressure: m_ready_i=0, 10 requests -> exactly 4 accepted, s_ready_o=0, level_o=4; m_ready_i=1 -> beats 0..3 drained then remaining resume, none lost.
REQ-043 Burst end: 3-beat burst, s_last_i on 3rd -> m_last_o only on 3rd beat, done_o one-cycle pulse on its transfer.
REQ-044 Full with simultaneous pop: level_o=4, m_transfer and s_valid_i same cycle -> request accepted, level_o stays 4.
REQ-045 Reset mid-stream: rst_ni low with 3 in flight -> all outputs 0; after release level_o=0, no beats emitted until new request.
